stopwatch_timer_dp: RTL and testbench
=====================================

Name: stopwatch_timer_dp

Overview:
- Parametrised successor of the stopwatch datapath: a 100 Hz-resolution hh:mm:ss:cc counter that counts up (stopwatch) or down (countdown timer).
- Adds preset load, lap capture and a countdown-done pulse.
- Sits between the control FSM (run/stop, clear, mode, load, lap strobes) and the FND display mux.
- Single clock domain; all control inputs are synchronous, already-debounced single-cycle pulses, except i_runstop and i_mode, which are levels.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond tick rate. FCOUNT = CLK_FREQ/TICK_HZ, which must be ≥ 2.
- HOUR_MAX, 24, hour modulus (legal range 2..99). HW = $clog2(HOUR_MAX).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_runstop  in  1  level. 1 = prescaler advances, 0 = frozen.
- i_clear  in  1  pulse. Zeroes time, lap and prescaler.
- i_mode  in  1  level. 0 = count up, 1 = count down.
- i_load  in  1  pulse. Loads the preset fields.
- i_ld_msec  in  7  preset centiseconds.
- i_ld_sec  in  6  preset seconds.
- i_ld_min  in  6  preset minutes.
- i_ld_hour  in  HW  preset hours.
- i_lap  in  1  pulse. Captures the current time into the lap registers.
- o_msec  out  7  centiseconds, 0..99.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  HW  hours, 0..HOUR_MAX-1.
- o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour  out  7/6/6/HW  captured lap time.
- o_lap_valid  out  1  lap registers hold a capture.
- o_done  out  1  one-cycle pulse when the countdown reaches 00:00:00:00.

Behaviour:
- Reset (rst=0, async): all time, lap, prescaler and tick registers are 0; o_lap_valid=0; o_done=0.
- Prescaler:
  - Counts 0..FCOUNT-1 only while i_runstop=1 and not halted.
  - On a wrap it asserts the registered internal tick for exactly one cycle.
  - The time update happens on the cycle after the wrap, so there is one cycle of latency from wrap to the field change.
  - When i_runstop=0, count and tick hold; resuming continues from the held count.
- Up mode:
  - Each tick increments msec.
  - 99→0 carries into sec; 59→0 carries into min; 59→0 carries into hour.
  - HOUR_MAX-1→0 wraps the whole counter to zero, with no flag.
  - All carries resolve in the same cycle.
- Down mode:
  - Each tick decrements msec.
  - 0→99 borrows from sec; 0→59 borrows from min; 0→59 borrows from hour.
  - The tick that produces all-zero fields also asserts o_done (registered, same cycle as the fields become zero) and sets the internal halt flag.
  - While halted and at zero, ticks are ignored, the prescaler holds, and there is no underflow.
  - Halt clears on i_clear, i_load, or i_mode changing to 0.
  - A tick arriving while already at zero in down mode (e.g. a run with no preset) sets halt without pulsing o_done.
- Mode switch mid-count takes effect on the next tick. No field values change on the switch.
- Priority in one cycle: i_clear > i_load > tick. i_lap is independent.
- i_clear:
  - Time fields, prescaler and lap fields go to 0.
  - o_lap_valid=0 and halt=0.
  - Any pending tick is discarded.
- i_load:
  - Fields are taken from the preset inputs, each clamped to its maximum: msec>99→99, sec/min>59→59, hour≥HOUR_MAX→HOUR_MAX-1.
  - The prescaler resets to 0 and a same-cycle tick is discarded.
- i_lap:
  - Captures the current o_* values (the pre-tick value if a tick lands in the same cycle).
  - Sets o_lap_valid=1, and it stays set until clear or reset.
  - i_lap together with i_clear: clear wins, so lap is 0 and o_lap_valid=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Setup: CLK_FREQ=1000, TICK_HZ=100 (FCOUNT=10), HOUR_MAX=24.
- Reset mid-run: drive rst=0 asynchronously between clock edges → all outputs 0 immediately, o_lap_valid=0.
- Up-count carry chain: load 23:59:59:98, i_mode=0, run. First tick → 23:59:59:99; second tick → 00:00:00:00 with no o_done. Tick spacing is exactly 10 clocks.
- Countdown: load 00:00:01:01, i_mode=1, run.
  - Tick → 00:00:01:00; tick → 00:00:00:99; then 99 further ticks → 00:00:00:00.
  - o_done is high for exactly 1 cycle, the fields then hold at 0 for 50 further clocks, and the prescaler is frozen.
- Load clamping: i_ld_msec=120, i_ld_sec=63, i_ld_min=60, i_ld_hour=30 → 23:59:59:99 displayed.
- Lap and simultaneity: at 00:00:03:07, pulse i_lap on the same cycle the tick applies → lap shows 00:00:03:07, live shows 00:00:03:08, o_lap_valid=1.
- Same-cycle priority: pulse i_clear with i_lap → all 0 and o_lap_valid=0.
- Pause/resume: run 7 clocks, drop i_runstop for 20 clocks, then raise it → next tick after 3 more clocks, not 10.

Source files
------------

// File: rtl/stopwatch_timer_dp.sv
//------------------------------------------------------------------------------
// stopwatch_timer_dp
//
// hh:mm:ss:cc time datapath for the stopwatch / countdown timer. A prescaler
// divides clk down to TICK_HZ. Each tick advances the time fields up
// (stopwatch) or down (countdown timer) with full carry/borrow resolution in
// a single cycle. Preset load, lap capture and a countdown-done pulse are
// provided for the control FSM. The FND display mux reads the outputs.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous reset, active low
//   i_runstop           level: 1 = prescaler advances, 0 = frozen
//   i_clear             pulse: zero time, lap and prescaler
//   i_mode              level: 0 = count up, 1 = count down
//   i_load              pulse: load clamped preset fields
//   i_ld_msec/sec/min/hour  preset values
//   i_lap               pulse: capture current time into lap registers
//   o_msec/sec/min/hour live time (registered)
//   o_lap_*             captured lap time (registered)
//   o_lap_valid         lap registers hold a capture
//   o_done              one-cycle pulse when a countdown reaches zero
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_timer_dp #(
    parameter int  CLK_FREQ = 100_000_000,
    parameter int  TICK_HZ  = 100,
    parameter int  HOUR_MAX = 24,
    localparam int HW       = $clog2(HOUR_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_runstop,
    input  logic          i_clear,
    input  logic          i_mode,
    input  logic          i_load,
    input  logic [6:0]    i_ld_msec,
    input  logic [5:0]    i_ld_sec,
    input  logic [5:0]    i_ld_min,
    input  logic [HW-1:0] i_ld_hour,
    input  logic          i_lap,
    output logic [6:0]    o_msec,
    output logic [5:0]    o_sec,
    output logic [5:0]    o_min,
    output logic [HW-1:0] o_hour,
    output logic [6:0]    o_lap_msec,
    output logic [5:0]    o_lap_sec,
    output logic [5:0]    o_lap_min,
    output logic [HW-1:0] o_lap_hour,
    output logic          o_lap_valid,
    output logic          o_done
);

    localparam int            FCOUNT    = CLK_FREQ / TICK_HZ;
    localparam int            CW        = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(FCOUNT - 1);
    localparam logic [HW-1:0] HOUR_LAST = HW'(HOUR_MAX - 1);
    localparam logic [HW-1:0] HOUR_ZERO = {HW{1'b0}};

    // Preset clamp helpers: out-of-range presets saturate at the field maximum.
    function automatic logic [6:0] clamp_msec(input logic [6:0] v);
        clamp_msec = (v > 7'd99) ? 7'd99 : v;
    endfunction

    function automatic logic [5:0] clamp_sixty(input logic [5:0] v);
        clamp_sixty = (v > 6'd59) ? 6'd59 : v;
    endfunction

    function automatic logic [HW-1:0] clamp_hour(input logic [HW-1:0] v);
        clamp_hour = (v > HOUR_LAST) ? HOUR_LAST : v;
    endfunction

    // Registers
    logic [CW-1:0] cnt_r;
    logic          tick_r;
    logic          halt_r;
    logic          mode_d_r;
    logic          done_r;
    logic [6:0]    msec_r;
    logic [5:0]    sec_r;
    logic [5:0]    min_r;
    logic [HW-1:0] hour_r;
    logic [6:0]    lap_msec_r;
    logic [5:0]    lap_sec_r;
    logic [5:0]    lap_min_r;
    logic [HW-1:0] lap_hour_r;
    logic          lap_valid_r;

    // Next-state signals
    logic [6:0]    msec_nx_s;
    logic [5:0]    sec_nx_s;
    logic [5:0]    min_nx_s;
    logic [HW-1:0] hour_nx_s;
    logic          halt_nx_s;
    logic          done_nx_s;
    logic          at_zero_s;
    logic          at_one_s;
    logic          mode_fall_s;

    assign at_zero_s   = (msec_r == 7'd0) && (sec_r == 6'd0) &&
                         (min_r == 6'd0) && (hour_r == HOUR_ZERO);
    assign at_one_s    = (msec_r == 7'd1) && (sec_r == 6'd0) &&
                         (min_r == 6'd0) && (hour_r == HOUR_ZERO);
    // Leaving countdown mode releases a halted timer.
    assign mode_fall_s = mode_d_r & ~i_mode;

    // Prescaler: free-runs while enabled, registered one-cycle tick on wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (i_clear || i_load) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (i_runstop && !halt_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r  <= {CW{1'b0}};
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CW'(1);
                tick_r <= 1'b0;
            end
        end else begin
            cnt_r  <= cnt_r;
            tick_r <= 1'b0;
        end
    end

    // Time field next-state: clear > load > tick, carries resolved in one pass.
    always_comb begin
        msec_nx_s = msec_r;
        sec_nx_s  = sec_r;
        min_nx_s  = min_r;
        hour_nx_s = hour_r;
        halt_nx_s = halt_r;
        done_nx_s = 1'b0;

        if (i_clear) begin
            msec_nx_s = 7'd0;
            sec_nx_s  = 6'd0;
            min_nx_s  = 6'd0;
            hour_nx_s = HOUR_ZERO;
            halt_nx_s = 1'b0;
        end else if (i_load) begin
            msec_nx_s = clamp_msec(i_ld_msec);
            sec_nx_s  = clamp_sixty(i_ld_sec);
            min_nx_s  = clamp_sixty(i_ld_min);
            hour_nx_s = clamp_hour(i_ld_hour);
            halt_nx_s = 1'b0;
        end else begin
            if (mode_fall_s) begin
                halt_nx_s = 1'b0;
            end else begin
                halt_nx_s = halt_r;
            end

            if (tick_r && !halt_r) begin
                if (!i_mode) begin
                    // Count up; the top of the hour range wraps silently to zero.
                    if (msec_r != 7'd99) begin
                        msec_nx_s = msec_r + 7'd1;
                    end else begin
                        msec_nx_s = 7'd0;
                        if (sec_r != 6'd59) begin
                            sec_nx_s = sec_r + 6'd1;
                        end else begin
                            sec_nx_s = 6'd0;
                            if (min_r != 6'd59) begin
                                min_nx_s = min_r + 6'd1;
                            end else begin
                                min_nx_s = 6'd0;
                                if (hour_r != HOUR_LAST) begin
                                    hour_nx_s = hour_r + HW'(1);
                                end else begin
                                    hour_nx_s = HOUR_ZERO;
                                end
                            end
                        end
                    end
                end else if (at_zero_s) begin
                    // Already at zero (e.g. run without preset): park, no pulse.
                    halt_nx_s = 1'b1;
                end else begin
                    // Count down; at_zero_s excluded, so some higher field is
                    // non-zero whenever a borrow propagates.
                    if (msec_r != 7'd0) begin
                        msec_nx_s = msec_r - 7'd1;
                    end else begin
                        msec_nx_s = 7'd99;
                        if (sec_r != 6'd0) begin
                            sec_nx_s = sec_r - 6'd1;
                        end else begin
                            sec_nx_s = 6'd59;
                            if (min_r != 6'd0) begin
                                min_nx_s = min_r - 6'd1;
                            end else begin
                                min_nx_s = 6'd59;
                                if (hour_r != HOUR_ZERO) begin
                                    hour_nx_s = hour_r - HW'(1);
                                end else begin
                                    hour_nx_s = HOUR_LAST;
                                end
                            end
                        end
                    end
                    if (at_one_s) begin
                        done_nx_s = 1'b1;
                        halt_nx_s = 1'b1;
                    end else begin
                        done_nx_s = 1'b0;
                    end
                end
            end else begin
                done_nx_s = 1'b0;
            end
        end
    end

    // Time, halt, done and mode-history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msec_r   <= 7'd0;
            sec_r    <= 6'd0;
            min_r    <= 6'd0;
            hour_r   <= HOUR_ZERO;
            halt_r   <= 1'b0;
            done_r   <= 1'b0;
            mode_d_r <= 1'b0;
        end else begin
            msec_r   <= msec_nx_s;
            sec_r    <= sec_nx_s;
            min_r    <= min_nx_s;
            hour_r   <= hour_nx_s;
            halt_r   <= halt_nx_s;
            done_r   <= done_nx_s;
            mode_d_r <= i_mode;
        end
    end

    // Lap capture: samples the pre-tick live value; clear overrides capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_msec_r  <= 7'd0;
            lap_sec_r   <= 6'd0;
            lap_min_r   <= 6'd0;
            lap_hour_r  <= HOUR_ZERO;
            lap_valid_r <= 1'b0;
        end else if (i_clear) begin
            lap_msec_r  <= 7'd0;
            lap_sec_r   <= 6'd0;
            lap_min_r   <= 6'd0;
            lap_hour_r  <= HOUR_ZERO;
            lap_valid_r <= 1'b0;
        end else if (i_lap) begin
            lap_msec_r  <= msec_r;
            lap_sec_r   <= sec_r;
            lap_min_r   <= min_r;
            lap_hour_r  <= hour_r;
            lap_valid_r <= 1'b1;
        end else begin
            lap_msec_r  <= lap_msec_r;
            lap_sec_r   <= lap_sec_r;
            lap_min_r   <= lap_min_r;
            lap_hour_r  <= lap_hour_r;
            lap_valid_r <= lap_valid_r;
        end
    end

    assign o_msec      = msec_r;
    assign o_sec       = sec_r;
    assign o_min       = min_r;
    assign o_hour      = hour_r;
    assign o_lap_msec  = lap_msec_r;
    assign o_lap_sec   = lap_sec_r;
    assign o_lap_min   = lap_min_r;
    assign o_lap_hour  = lap_hour_r;
    assign o_lap_valid = lap_valid_r;
    assign o_done      = done_r;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_timer_dp.sv
//------------------------------------------------------------------------------
// tb_stopwatch_timer_dp
//
// Directed scenarios followed by a randomized phase. A reference model keeps
// time as a single centisecond total (plain modular arithmetic) and is
// compared against the DUT after every clock edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stopwatch_timer_dp;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int HOUR_MAX = 24;
    localparam int HW       = 5;
    localparam int FCOUNT   = CLK_FREQ / TICK_HZ;
    localparam int DAY_CS   = HOUR_MAX * 360000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_runstop = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_mode = 1'b0;
    logic          i_load = 1'b0;
    logic [6:0]    i_ld_msec = 7'd0;
    logic [5:0]    i_ld_sec = 6'd0;
    logic [5:0]    i_ld_min = 6'd0;
    logic [HW-1:0] i_ld_hour = 5'd0;
    logic          i_lap = 1'b0;
    logic [6:0]    o_msec;
    logic [5:0]    o_sec;
    logic [5:0]    o_min;
    logic [HW-1:0] o_hour;
    logic [6:0]    o_lap_msec;
    logic [5:0]    o_lap_sec;
    logic [5:0]    o_lap_min;
    logic [HW-1:0] o_lap_hour;
    logic          o_lap_valid;
    logic          o_done;

    stopwatch_timer_dp #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .HOUR_MAX (HOUR_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_runstop   (i_runstop),
        .i_clear     (i_clear),
        .i_mode      (i_mode),
        .i_load      (i_load),
        .i_ld_msec   (i_ld_msec),
        .i_ld_sec    (i_ld_sec),
        .i_ld_min    (i_ld_min),
        .i_ld_hour   (i_ld_hour),
        .i_lap       (i_lap),
        .o_msec      (o_msec),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hour      (o_hour),
        .o_lap_msec  (o_lap_msec),
        .o_lap_sec   (o_lap_sec),
        .o_lap_min   (o_lap_min),
        .o_lap_hour  (o_lap_hour),
        .o_lap_valid (o_lap_valid),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    // Reference model state: time as total centiseconds.
    int m_total, m_lap_total, m_cnt;
    bit m_tick, m_lap_valid, m_done, m_halt, m_mode_d;

    logic [23:0] dut_time;
    logic [23:0] dut_lap;
    assign dut_time = {o_hour, o_min, o_sec, o_msec};
    assign dut_lap  = {o_lap_hour, o_lap_min, o_lap_sec, o_lap_msec};

    function automatic int to_total(input int h, input int m, input int s, input int c);
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    function automatic logic [23:0] pack_total(input int t);
        logic [4:0] h;
        logic [5:0] mi;
        logic [5:0] s;
        logic [6:0] c;
        h  = 5'(t / 360000);
        mi = 6'((t / 6000) % 60);
        s  = 6'((t / 100) % 60);
        c  = 7'(t % 100);
        return {h, mi, s, c};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_total = 0; m_lap_total = 0; m_cnt = 0;
        m_tick = 1'b0; m_lap_valid = 1'b0; m_done = 1'b0;
        m_halt = 1'b0; m_mode_d = 1'b0;
    endfunction

    // Advance the model by one clock edge from the current inputs.
    function automatic void model_step();
        bit old_halt;
        bit new_halt;
        if (!rst) begin
            model_reset();
            return;
        end
        old_halt = m_halt;
        m_done   = 1'b0;
        if (i_clear) begin
            m_lap_total = 0;
            m_lap_valid = 1'b0;
        end else if (i_lap) begin
            m_lap_total = m_total;
            m_lap_valid = 1'b1;
        end
        if (i_clear) begin
            m_total = 0; m_cnt = 0; m_tick = 1'b0; m_halt = 1'b0;
        end else if (i_load) begin
            m_total = to_total(imin(int'(i_ld_hour), HOUR_MAX - 1),
                               imin(int'(i_ld_min), 59),
                               imin(int'(i_ld_sec), 59),
                               imin(int'(i_ld_msec), 99));
            m_cnt = 0; m_tick = 1'b0; m_halt = 1'b0;
        end else begin
            new_halt = (m_mode_d && !i_mode) ? 1'b0 : old_halt;
            if (m_tick && !old_halt) begin
                if (!i_mode) begin
                    m_total = (m_total + 1) % DAY_CS;
                end else if (m_total == 0) begin
                    new_halt = 1'b1;
                end else begin
                    m_total = m_total - 1;
                    if (m_total == 0) begin
                        m_done   = 1'b1;
                        new_halt = 1'b1;
                    end
                end
            end
            if (i_runstop && !old_halt) begin
                m_tick = (m_cnt == FCOUNT - 1);
                m_cnt  = (m_cnt + 1) % FCOUNT;
            end else begin
                m_tick = 1'b0;
            end
            m_halt = new_halt;
        end
        m_mode_d = i_mode;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (o_done === 1'b1) done_seen++;
        chk("time", {8'd0, dut_time}, {8'd0, pack_total(m_total)});
        chk("lap", {8'd0, dut_lap}, {8'd0, pack_total(m_lap_total)});
        chk("lap_valid", {31'd0, o_lap_valid}, {31'd0, m_lap_valid});
        chk("done", {31'd0, o_done}, {31'd0, m_done});
    endtask

    // Run until the displayed time changes; n = clocks taken (bounded).
    task automatic wait_change(output int n);
        logic [23:0] prev;
        prev = dut_time;
        n = 0;
        do begin
            cycle();
            n++;
        end while (dut_time === prev && n < 40);
        chk("tick_seen", {31'd0, (dut_time !== prev)}, 32'd1);
    endtask

    task automatic do_load(input int h, input int m, input int s, input int c);
        i_ld_hour = 5'(h); i_ld_min = 6'(m); i_ld_sec = 6'(s); i_ld_msec = 7'(c);
        i_load = 1'b1;
        cycle();
        i_load = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();

        // Reset state
        #12;
        chk("rst_time", {8'd0, dut_time}, 32'd0);
        chk("rst_lap_valid", {31'd0, o_lap_valid}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Load clamping
        i_runstop = 1'b0;
        do_load(30, 60, 63, 120);
        chk("clamp", {8'd0, dut_time}, {8'd0, 5'd23, 6'd59, 6'd59, 7'd99});

        // Up-count carry chain through the day wrap
        i_mode = 1'b0;
        i_runstop = 1'b1;
        do_load(23, 59, 59, 98);
        wait_change(n);
        chk("up_first", {8'd0, dut_time}, {8'd0, 5'd23, 6'd59, 6'd59, 7'd99});
        wait_change(n);
        chk("up_spacing", 32'(n), 32'd10);
        chk("up_wrap", {8'd0, dut_time}, 32'd0);
        chk("up_wrap_nodone", {31'd0, o_done}, 32'd0);

        // Countdown to zero with a single done pulse, then a frozen hold
        i_mode = 1'b1;
        do_load(0, 0, 1, 1);
        done_seen = 0;
        wait_change(n);
        chk("dn_first", {8'd0, dut_time}, {8'd0, 5'd0, 6'd0, 6'd1, 7'd0});
        wait_change(n);
        chk("dn_borrow", {8'd0, dut_time}, {8'd0, 5'd0, 6'd0, 6'd0, 7'd99});
        for (int k = 0; k < 99; k++) wait_change(n);
        chk("dn_zero", {8'd0, dut_time}, 32'd0);
        chk("dn_done_now", {31'd0, o_done}, 32'd1);
        repeat (50) cycle();
        chk("dn_hold", {8'd0, dut_time}, 32'd0);
        chk("dn_done_once", 32'(done_seen), 32'd1);

        // Leaving countdown mode releases the halt; counting resumes upward
        i_mode = 1'b0;
        wait_change(n);
        chk("resume_up", {8'd0, dut_time}, 32'd1);

        // Lap captured on the same cycle the tick is applied
        do_load(0, 0, 3, 7);
        repeat (10) cycle();
        i_lap = 1'b1;
        cycle();
        i_lap = 1'b0;
        chk("lap_pre_tick", {8'd0, dut_lap}, {8'd0, 5'd0, 6'd0, 6'd3, 7'd7});
        chk("lap_live", {8'd0, dut_time}, {8'd0, 5'd0, 6'd0, 6'd3, 7'd8});
        chk("lap_valid_set", {31'd0, o_lap_valid}, 32'd1);

        // Clear beats lap in the same cycle
        i_clear = 1'b1;
        i_lap = 1'b1;
        cycle();
        i_clear = 1'b0;
        i_lap = 1'b0;
        chk("clr_time", {8'd0, dut_time}, 32'd0);
        chk("clr_lap", {8'd0, dut_lap}, 32'd0);
        chk("clr_lap_valid", {31'd0, o_lap_valid}, 32'd0);

        // Pause/resume: held prescaler count 7 -> tick after 3 clocks, field one later
        repeat (7) cycle();
        i_runstop = 1'b0;
        repeat (20) cycle();
        chk("pause_hold", {8'd0, dut_time}, 32'd0);
        i_runstop = 1'b1;
        wait_change(n);
        chk("resume_latency", 32'(n), 32'd4);

        // Countdown started at zero parks without a done pulse
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0;
        i_mode = 1'b1;
        done_seen = 0;
        repeat (30) cycle();
        chk("zero_run_nodone", 32'(done_seen), 32'd0);
        chk("zero_run_time", {8'd0, dut_time}, 32'd0);
        i_mode = 1'b0;
        cycle();

        // Randomized phase against the model
        i_mode = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            i_runstop = ($urandom_range(0, 9) != 32'd0);
            i_clear   = ($urandom_range(0, 499) == 32'd0);
            i_load    = ($urandom_range(0, 399) == 32'd0);
            i_lap     = ($urandom_range(0, 24) == 32'd0);
            if ($urandom_range(0, 599) == 32'd0) i_mode = ~i_mode;
            if ($urandom_range(0, 1) == 32'd0) begin
                i_ld_hour = 5'd0;
                i_ld_min  = 6'd0;
                i_ld_sec  = 6'($urandom_range(0, 1));
                i_ld_msec = 7'($urandom_range(0, 127));
            end else begin
                i_ld_hour = 5'($urandom_range(0, 31));
                i_ld_min  = 6'($urandom_range(0, 63));
                i_ld_sec  = 6'($urandom_range(0, 63));
                i_ld_msec = 7'($urandom_range(0, 127));
            end
            cycle();
        end
        i_clear = 1'b0;
        i_load = 1'b0;
        i_lap = 1'b0;

        // Asynchronous reset mid-run, between clock edges
        i_mode = 1'b0;
        i_runstop = 1'b1;
        do_load(1, 2, 3, 4);
        i_lap = 1'b1;
        cycle();
        i_lap = 1'b0;
        repeat (5) cycle();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_time", {8'd0, dut_time}, 32'd0);
        chk("arst_lap", {8'd0, dut_lap}, 32'd0);
        chk("arst_lap_valid", {31'd0, o_lap_valid}, 32'd0);
        chk("arst_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
